// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//
// UART transmitter. Accepts one data word per valid/ready handshake and
// serialises it onto `sout` as: start bit (0), DATA_BITS data bits LSB first,
// an optional parity bit, then STOP_BITS stop bits (1). Every bit is held for
// exactly 16 strobes of the shared 16x-baud enable `baud_tick_16x`.
//
// Handshake: a word is transferred on every rising clk edge where
// tx_valid && tx_ready. tx_ready is high only while the FSM is idle and not
// in reset; tx_valid while busy is ignored (there is no queue). tx_data,
// parity_en and odd_even_parity are captured at the transfer edge, so later
// changes to them cannot disturb a frame in flight.
//
// Ports:
//   clk              system clock
//   rst              synchronous reset, active-high
//   baud_tick_16x    one-cycle enable strobe at 16x the baud rate
//   parity_en        1 = append a parity bit
//   odd_even_parity  1 = odd parity, 0 = even parity
//   tx_data          word to transmit (DATA_BITS wide)
//   tx_valid         tx_data is valid
//   tx_ready         block can accept a word this cycle (combinational)
//   sout             registered serial output, idle high
//   tx_busy          registered, high while a frame is in progress
//   tx_done          registered, one-cycle pulse as the last stop bit ends
// -----------------------------------------------------------------------------
module uart_tx #(
   parameter int DATA_BITS = 8,   // 5..8
   parameter int STOP_BITS = 1    // 1 or 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 baud_tick_16x,
   input  logic                 parity_en,
   input  logic                 odd_even_parity,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 sout,
   output logic                 tx_busy,
   output logic                 tx_done
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   // Bit counter indexes data bits (0..DATA_BITS-1) in DATA and stop bits
   // (0..STOP_BITS-1) in STOP; three bits cover both ranges.
   localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
   localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

   state_t                 state_q,   state_d;
   logic [3:0]             tick_q,    tick_d;
   logic [2:0]             bit_q,     bit_d;
   logic [DATA_BITS-1:0]   shift_q,   shift_d;
   logic                   par_en_q,  par_en_d;
   logic                   par_bit_q, par_bit_d;
   logic                   sout_q,    sout_d;
   logic                   busy_q,    busy_d;
   logic                   done_q,    done_d;

   logic                   accept;
   logic                   bit_end;

   assign tx_ready = (state_q == S_IDLE) && !rst;
   assign accept   = tx_valid && tx_ready;

   // A bit period ends on the edge that samples its 16th strobe.
   assign bit_end  = baud_tick_16x && (tick_q == 4'd15);

   // --------------------------------------------------------------------------
   // Next-state and output logic
   // --------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      tick_d    = tick_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      par_en_d  = par_en_q;
      par_bit_d = par_bit_q;
      sout_d    = sout_q;
      busy_d    = busy_q;
      done_d    = 1'b0;

      // The tick counter only runs inside a frame, so a strobe seen in IDLE
      // (including one coincident with acceptance) never counts.
      if (state_q != S_IDLE && baud_tick_16x) begin
         tick_d = tick_q + 4'd1;
      end

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d   = S_START;
               shift_d   = tx_data;
               par_en_d  = parity_en;
               // Parity is resolved now so later input changes are irrelevant.
               // Even: bit makes the total count of ones even (= XOR of data).
               par_bit_d = odd_even_parity ? ~^tx_data : ^tx_data;
               sout_d    = 1'b0;
               busy_d    = 1'b1;
               tick_d    = 4'd0;
               bit_d     = 3'd0;
            end
         end

         S_START: begin
            if (bit_end) begin
               state_d = S_DATA;
               sout_d  = shift_q[0];
               shift_d = shift_q >> 1;
               tick_d  = 4'd0;
               bit_d   = 3'd0;
            end
         end

         S_DATA: begin
            if (bit_end) begin
               tick_d = 4'd0;
               if (bit_q == LAST_DATA) begin
                  bit_d = 3'd0;
                  if (par_en_q) begin
                     state_d = S_PARITY;
                     sout_d  = par_bit_q;
                  end else begin
                     state_d = S_STOP;
                     sout_d  = 1'b1;
                  end
               end else begin
                  bit_d   = bit_q + 3'd1;
                  sout_d  = shift_q[0];
                  shift_d = shift_q >> 1;
               end
            end
         end

         S_PARITY: begin
            if (bit_end) begin
               state_d = S_STOP;
               sout_d  = 1'b1;
               tick_d  = 4'd0;
               bit_d   = 3'd0;
            end
         end

         S_STOP: begin
            if (bit_end) begin
               tick_d = 4'd0;
               if (bit_q == LAST_STOP) begin
                  // Frame complete; tx_ready rises combinationally next cycle,
                  // so a held tx_valid starts the next frame with no idle gap.
                  state_d = S_IDLE;
                  bit_d   = 3'd0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
            sout_d  = 1'b1;
            busy_d  = 1'b0;
            tick_d  = 4'd0;
            bit_d   = 3'd0;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // State register
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         tick_q    <= 4'd0;
         bit_q     <= 3'd0;
         shift_q   <= '0;
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
         sout_q    <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         tick_q    <= tick_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         par_en_q  <= par_en_d;
         par_bit_q <= par_bit_d;
         sout_q    <= sout_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign sout    = sout_q;
   assign tx_busy = busy_q;
   assign tx_done = done_q;

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter; the upstream partner of uart_rx on the serial link. It accepts one byte per valid/ready handshake and serialises it onto `sout` as start bit, data LSB-first, optional parity bit, then stop bit(s). Bit timing comes from the same shared `baud_tick_16x` strobe that uart_rx uses for oversampling. Each bit is held for exactly 16 ticks.

Parameters:
DATA_BITS, 8, data bits per frame (5..8 supported); `tx_data` width.
STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
baud_tick_16x  input  1  one-clk-cycle enable strobe at 16x baud rate, synchronous to clk
parity_en  input  1  1 = append parity bit
odd_even_parity  input  1  1 = odd parity, 0 = even parity
tx_data  input  DATA_BITS  byte to transmit
tx_valid  input  1  tx_data valid
tx_ready  output  1  block can accept a byte this cycle
sout  output  1  serial output, idle high
tx_busy  output  1  frame in progress
tx_done  output  1  one-cycle pulse when the last stop bit completes

Behaviour:
- Clock is clk; reset is synchronous, active-high (rst). All state updates on posedge clk.
- Reset values:
  - state = IDLE, sout = 1, tx_busy = 0, tx_done = 0.
  - tick counter = 0, bit counter = 0, shift register = 0.
- tx_ready = (state == IDLE) && !rst.
- Acceptance:
  - A byte is accepted on any posedge where tx_valid && tx_ready.
  - At acceptance, latch tx_data, parity_en and odd_even_parity. Changes to these inputs mid-frame have no effect.
  - tx_valid while busy is ignored; no queueing.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on acceptance. sout = 0 and tx_busy = 1 from the next cycle.
  - Every state except IDLE lasts exactly 16 baud_tick_16x strobes. A 4-bit tick counter is reset to 0 on state entry and increments on each strobe. The state ends on the clk edge that samples the 16th strobe.
  - START -> DATA. sout = shift[0]; shift right on each bit boundary.
  - DATA holds DATA_BITS bits, counted by the bit counter. After the last bit:
    - -> PARITY if parity_en was latched high,
    - otherwise -> STOP.
  - PARITY: sout = ^data when even parity, ~^data when odd parity.
  - STOP: sout = 1 for STOP_BITS x 16 strobes.
  - STOP -> IDLE. On that same edge: tx_done = 1 for one cycle, tx_busy = 0, tx_ready = 1.
- Back-to-back: tx_valid held high in IDLE is accepted on the first IDLE cycle, so a new start bit begins one clk after the previous stop bit ends. No extra idle bit is inserted.
- Output timing:
  - sout is registered; changes only on state/bit boundaries. No glitches.
  - Between frames sout = 1.
- Frame length = (1 + DATA_BITS + parity + STOP_BITS) x 16 strobes.
- Reset mid-frame: next edge returns to IDLE with sout = 1 and no tx_done; the partial frame is abandoned.
- Strobe edge cases:
  - Strobe asserted in IDLE: no effect.
  - Strobe coincident with acceptance: does not count toward the start bit.
- Registered outputs are sout, tx_busy and tx_done; tx_ready is combinational.

Test Plan:
1. Reset / idle: hold rst 3 cycles with tx_valid = 1 -> sout = 1, tx_busy = 0, tx_done = 0, no byte accepted; tx_ready = 1 on the first cycle after rst drops.
2. Basic frame:
   - Stimulus: strobe every 4 clk, parity off, send 0x65.
   - sout sequence: 0, 1,0,1,0,0,1,1,0, 1; each bit 64 clk; total frame 640 clk.
   - tx_done pulses once; looping sout into uart_rx gives rx_data = 0x65 with rx_valid.
3. Parity:
   - Send 0x07 with even parity -> parity bit = 1.
   - Send 0x07 with odd parity -> parity bit = 0.
   - Send 0x00 with even parity -> parity bit = 0.
   - Each frame is 11 bits = 176 strobes.
4. Back-to-back: hold tx_valid with 0x65 then 0x03 -> second start bit falls 1 clk after tx_done, no idle gap; uart_rx reports 0x65 then 0x03.
5. Busy / no queueing: pulse tx_valid with 0xFF during the DATA state of 0x65 -> ignored; only 0x65 is transmitted; changing parity_en mid-frame does not alter the frame.
6. Reset mid-frame: assert rst during data bit 4 of 0x65 -> sout = 1 on the next edge, no tx_done; a byte 0x5A sent afterwards transmits correctly.
